// File: rtl/merge_arbiter.sv
// Purpose: merges NUM_IN packetised flit sources onto one output and locks onto a source for a whole packet.
// Latency: one cycle of arbitration from head valid to grant, then the output is combinational from the granted source.
// Backpressure: out_ready goes straight to the granted in_ready. Sources that are not granted see ready=0 and hold their flits.
//
// Ports:
//   clk, rstn             clock; asynchronous active-low reset
//   in_valid/in_ready     per-source handshake; at most one in_ready bit is set
//   in_data               packed flits, source i at [i*DW +: DW]; type in the top two bits
//   out_valid/out_ready   merged output handshake
//   out_data              merged flit, zero while idle
//   grant_id              locked source index, zero while idle
//   busy                  high while a source is locked
//   pkt_cnt               count of completed packets, wrapping at 16 bits
//   err_proto             sticky protocol-error flag
module merge_arbiter #(
  parameter int NUM_IN = 4,
  parameter int DW     = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NUM_IN-1:0]    in_valid,
  output logic [NUM_IN-1:0]    in_ready,
  input  logic [NUM_IN*DW-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        out_data,
  output logic [2:0]           grant_id,
  output logic                 busy,
  output logic [15:0]          pkt_cnt,
  output logic                 err_proto
);

  localparam int PW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic [2:0]    grant_q, grant_d;
  logic [15:0]   pkt_cnt_q, pkt_cnt_d;
  logic          err_q, err_d;
  // Set once the granted source has moved its first flit. Any later head or single flit is then a protocol error.
  logic          head_seen_q, head_seen_d;

  // Flit type bit DW-2 is set for head (01) and single (11), so it marks a packet start.
  // Bit DW-1 is set for tail (10) and single (11), so it marks a packet end.
  logic [NUM_IN-1:0] req;
  logic [NUM_IN-1:0] orphan;

  for (genvar g = 0; g < NUM_IN; g++) begin : g_dec
    assign req[g]    = in_valid[g] &  in_data[g*DW + DW-2];
    assign orphan[g] = in_valid[g] & ~in_data[g*DW + DW-2];
  end

  // Round-robin search: take the first requester at or after rr_ptr, wrapping at NUM_IN.
  logic          arb_found;
  logic [PW-1:0] arb_sel;

  always_comb begin
    int idx;
    arb_found = 1'b0;
    arb_sel   = '0;
    idx       = 0;
    for (int k = 0; k < NUM_IN; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_IN;
      if (!arb_found && req[idx]) begin
        arb_found = 1'b1;
        arb_sel   = PW'(idx);
      end
    end
  end

  // Mux in the granted source.
  logic          sel_valid;
  logic [DW-1:0] sel_data;

  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (int'(grant_q) == i) begin
        sel_valid = in_valid[i];
        sel_data  = in_data[i*DW +: DW];
      end
    end
  end

  // Next-state logic and outputs.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    pkt_cnt_d   = pkt_cnt_q;
    err_d       = err_q;
    head_seen_d = head_seen_q;
    out_valid   = 1'b0;
    out_data    = '0;
    in_ready    = '0;

    case (state_q)
      IDLE: begin
        // Body or tail flits with no packet open are orphans. They are flagged but never consumed.
        if (|orphan) err_d = 1'b1;
        if (arb_found) begin
          state_d     = LOCKED;
          grant_d     = 3'(arb_sel);
          head_seen_d = 1'b0;
        end
      end

      LOCKED: begin
        out_valid = sel_valid;
        out_data  = sel_data;
        for (int i = 0; i < NUM_IN; i++) begin
          if (int'(grant_q) == i) in_ready[i] = out_ready;
        end

        if (sel_valid && sel_data[DW-2] && head_seen_q) err_d = 1'b1;

        if (sel_valid && out_ready) begin
          head_seen_d = 1'b1;
          if (sel_data[DW-1]) begin
            state_d     = IDLE;
            grant_d     = 3'd0;
            head_seen_d = 1'b0;
            pkt_cnt_d   = pkt_cnt_q + 16'd1;
            if (int'(grant_q) >= NUM_IN - 1) rr_ptr_d = '0;
            else                             rr_ptr_d = PW'(grant_q + 3'd1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= 3'd0;
      pkt_cnt_q   <= 16'd0;
      err_q       <= 1'b0;
      head_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      pkt_cnt_q   <= pkt_cnt_d;
      err_q       <= err_d;
      head_seen_q <= head_seen_d;
    end
  end

  assign grant_id  = grant_q;
  assign busy      = (state_q == LOCKED);
  assign pkt_cnt   = pkt_cnt_q;
  assign err_proto = err_q;

endmodule

// File: doc/merge_arbiter.md
MERGE_ARBITER -- requirements
Module: merge_arbiter

Interface
REQ-001 Parameter NUM_IN, default 4, number of merge source ports (2..8).
REQ-002 Parameter DW, default 32, flit width; flit type is data[DW-1:DW-2] (01 head, 00 body, 10 tail, 11 single).
REQ-003 clk  input  1  clock; all state updates on posedge clk.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  NUM_IN  per-source flit valid.
REQ-006 in_ready  output  NUM_IN  per-source ready; at most one bit set in any cycle.
REQ-007 in_data  input  NUM_IN*DW  packed flits; source i occupies bits [i*DW +: DW].
REQ-008 out_valid  output  1  merged flit valid.
REQ-009 out_ready  input  1  downstream ready.
REQ-010 out_data  output  DW  merged flit.
REQ-011 grant_id  output  3  index of the locked source; 0 when idle.
REQ-012 busy  output  1  high while in LOCKED.
REQ-013 pkt_cnt  output  16  completed packets; wraps 0xFFFF -> 0.
REQ-014 err_proto  output  1  sticky protocol-error flag.

Function
REQ-015 States IDLE and LOCKED; the round-robin pointer rr_ptr is log2(NUM_IN) bits wide.
REQ-016 A request exists from source i when in_valid[i]=1 and flit type is head or single.
REQ-017 In IDLE, the block shall select the first requesting source at or after rr_ptr (ascending, wrapping at NUM_IN), register it as grant_id, and enter LOCKED on the next edge: one-cycle arbitration latency.
REQ-018 In IDLE: out_valid=0, in_ready all 0, out_data=0.
REQ-019 In LOCKED: out_valid=in_valid[grant_id], out_data=in_data[grant_id], in_ready[grant_id]=out_ready, all other in_ready=0, all combinational.
REQ-020 A transfer occurs when out_valid & out_ready are both high.
REQ-021 A transfer of a tail or single flit in LOCKED shall cause: return to IDLE, rr_ptr <= grant_id+1 (mod NUM_IN), pkt_cnt+1, all on the same edge.
REQ-022 A transfer of a head or body flit shall keep LOCKED; grant is never revoked mid-packet.
REQ-023 A valid head or single flit from the granted source after its head, while LOCKED, shall set err_proto; it is forwarded unchanged.
REQ-024 A non-granted source presenting a valid body or tail flit while in IDLE shall set err_proto; it is not a request and is not consumed.
REQ-025 Non-granted sources are never consumed and their flits are held upstream; out_data is stable while out_valid=1 and out_ready=0.
REQ-026 Simultaneous requests are resolved only by rr_ptr; no source shall wait more than NUM_IN-1 packets.
REQ-027 With no request in IDLE, the block shall stay in IDLE and rr_ptr shall be unchanged.

Reset
REQ-028 rstn=0 shall immediately force: state IDLE, rr_ptr=0, grant_id=0, busy=0, pkt_cnt=0, err_proto=0, out_valid=0, in_ready=0.
REQ-029 rstn asserted mid-packet shall abandon the packet; after release, arbitration restarts from source 0 and the partial packet's remaining flits count as protocol errors if presented without a head.

Verification
REQ-030 Single source 0 sends head,body,tail with out_ready=1 -> grant_id=0 one cycle after head valid, 3 consecutive transfers, pkt_cnt=1, busy=0 after tail.
REQ-031 All 4 sources hold a single flit from reset -> output order 0,1,2,3, then 0 again; pkt_cnt=4 after the fourth.
REQ-032 Source 1 mid-packet, source 0 raises head -> source 1 completes all flits before source 0 is granted; in_ready[0]=0 throughout.
REQ-033 out_ready toggled 1,0,0,1 during a body flit -> out_data held constant for the stalled cycles, no flit lost or duplicated.
REQ-034 Source 2 presents a tail flit while in IDLE -> err_proto=1 next cycle and stays 1; in_ready[2]=0.
REQ-035 rstn pulsed low during a body flit of source 3 -> outputs reset immediately; pkt_cnt=0; the next head from source 0 is granted first.
